// File: rtl/bdc_line_scheduler.sv
// Line-buffer row scheduler for a barrel-distortion corrector: tracks stored input rows
// against completed output rows and releases each output row once its lookahead is buffered.
module bdc_line_scheduler #(
  parameter int unsigned HEIGHT       = 1080,
  parameter int unsigned BUFFER_LINES = 4,
  parameter int unsigned LOOKAHEAD    = 1,
  parameter int unsigned COORD_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start_i,
  input  logic                   line_done_i,
  output logic                   line_accept_o,
  output logic                   row_start_o,
  output logic [COORD_WIDTH-1:0] row_y_o,
  input  logic                   row_done_i,
  output logic                   frame_busy_o,
  output logic                   frame_done_o,
  output logic                   err_o
);

  localparam int unsigned CW = COORD_WIDTH;
  localparam int unsigned NW = COORD_WIDTH + 1;
  localparam logic [NW-1:0] L_HEIGHT = NW'(HEIGHT);
  localparam logic [NW-1:0] L_LOOK1  = NW'(LOOKAHEAD + 1);
  localparam logic [NW-1:0] L_BUF    = NW'(BUFFER_LINES);
  localparam logic [CW-1:0] L_LAST   = CW'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT_ROW,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_lines_wr;
  logic [CW-1:0] r_rows_done;
  logic [CW-1:0] r_row_y;
  logic          r_line_accept;
  logic          r_row_start;
  logic          r_busy;
  logic          r_frame_done;
  logic          r_err;

  logic [NW-1:0] w_need_raw;
  logic [NW-1:0] w_need;
  logic          w_fill_ok;
  logic          w_row_inc;
  logic          w_line_room;
  logic          w_line_inc;
  logic          w_last;
  logic          w_busy_nxt;
  logic [CW-1:0] w_lines_nxt;
  logic [CW-1:0] w_rows_nxt;
  logic [CW-1:0] w_occ_nxt;
  logic          w_accept_nxt;
  logic          w_abort;
  logic          w_err;

  // Rows needed before the current output row may start, clamped at the frame bottom.
  assign w_need_raw = {1'b0, r_row_y} + L_LOOK1;
  assign w_need     = (w_need_raw > L_HEIGHT) ? L_HEIGHT : w_need_raw;
  assign w_fill_ok  = ({1'b0, r_lines_wr} >= w_need);

  // A row completing in the same cycle frees a slot, so a full buffer may still take a line.
  assign w_row_inc   = row_done_i && (r_state == S_WAIT_ROW);
  assign w_line_room = r_line_accept ||
                       (w_row_inc && r_busy && ({1'b0, r_lines_wr} < L_HEIGHT));
  assign w_line_inc  = line_done_i && w_line_room;
  assign w_last      = w_row_inc && (r_row_y == L_LAST);

  assign w_lines_nxt = frame_start_i ? '0 : r_lines_wr + CW'(w_line_inc);
  assign w_rows_nxt  = frame_start_i ? '0 : r_rows_done + CW'(w_row_inc);
  assign w_occ_nxt   = w_lines_nxt - w_rows_nxt;
  assign w_busy_nxt  = frame_start_i ? 1'b1 : (w_last ? 1'b0 : r_busy);

  // Accept is computed from post-edge counters so it never lags the buffer state.
  assign w_accept_nxt = w_busy_nxt && (NW'(w_occ_nxt) < L_BUF) &&
                        (NW'(w_lines_nxt) < L_HEIGHT);

  assign w_abort = frame_start_i &&
                   ((r_state == S_FILL) || (r_state == S_ISSUE) || (r_state == S_WAIT_ROW));
  assign w_err   = (line_done_i && !w_line_room) ||
                   (row_done_i && (r_state != S_WAIT_ROW)) ||
                   w_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_lines_wr    <= '0;
      r_rows_done   <= '0;
      r_row_y       <= '0;
      r_line_accept <= 1'b0;
      r_row_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_lines_wr    <= w_lines_nxt;
      r_rows_done   <= w_rows_nxt;
      r_busy        <= w_busy_nxt;
      r_line_accept <= w_accept_nxt;
      r_row_start   <= 1'b0;
      r_frame_done  <= 1'b0;
      if (w_err) begin
        r_err <= 1'b1;
      end
      if (frame_start_i) begin
        r_state <= S_FILL;
        r_row_y <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_FILL: begin
            if (w_fill_ok) begin
              r_state     <= S_ISSUE;
              r_row_start <= 1'b1;
            end
          end
          S_ISSUE: r_state <= S_WAIT_ROW;
          S_WAIT_ROW: begin
            if (w_row_inc) begin
              if (w_last) begin
                r_state      <= S_DONE;
                r_frame_done <= 1'b1;
              end else begin
                r_row_y <= r_row_y + CW'(1);
                r_state <= S_FILL;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign line_accept_o = r_line_accept;
  assign row_start_o   = r_row_start;
  assign row_y_o       = r_row_y;
  assign frame_busy_o  = r_busy;
  assign frame_done_o  = r_frame_done;
  assign err_o         = r_err;

endmodule
